cpu_pc_seq: RTL and testbench

CPU_PC_SEQ -- requirements
Module: cpu_pc_seq

---
 rtl/cpu_pc_seq_if.sv | 29 ++
 rtl/cpu_pc_seq.sv | 123 ++++++++++++
 tb/tb_cpu_pc_seq.sv | 302 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cpu_pc_seq_if.sv
// Sequencer control bus: opcode, target and flags in; PC and status out.
interface cpu_pc_seq_if #(
   parameter int unsigned AW    = 8,
   parameter int unsigned DEPTH = 4
);
   localparam int unsigned SPW = $clog2(DEPTH) + 1;

   logic           EN;
   logic [2:0]     OP;
   logic [AW-1:0]  TARGET;
   logic           C;
   logic           Z;
   logic           B;
   logic [AW-1:0]  PC;
   logic           TAKEN;
   logic           HALTED;
   logic           STK_ERR;
   logic [SPW-1:0] SP;

   modport master (
      output EN, OP, TARGET, C, Z, B,
      input  PC, TAKEN, HALTED, STK_ERR, SP
   );

   modport slave (
      input  EN, OP, TARGET, C, Z, B,
      output PC, TAKEN, HALTED, STK_ERR, SP
   );
endinterface

// File: rtl/cpu_pc_seq.sv
// Program-counter sequencer with conditional jumps, call/return stack and halt state.
module cpu_pc_seq #(
   parameter int unsigned AW    = 8,
   parameter int unsigned DEPTH = 4
) (
   input  logic         CLK,
   input  logic         RST,
   cpu_pc_seq_if.slave  bus
);
   localparam int unsigned IW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned SPW = $clog2(DEPTH) + 1;

   typedef enum logic [2:0] {
      OP_NEXT = 3'b000,
      OP_JMP  = 3'b001,
      OP_JC   = 3'b010,
      OP_JZ   = 3'b011,
      OP_JB   = 3'b100,
      OP_CALL = 3'b101,
      OP_RET  = 3'b110,
      OP_HALT = 3'b111
   } op_e;

   typedef enum logic {
      S_RUN  = 1'b0,
      S_HALT = 1'b1
   } state_e;

   state_e         state_q, state_d;
   logic [AW-1:0]  pc_q, pc_d;
   logic [SPW-1:0] sp_q, sp_d;
   logic           taken_q, taken_d;
   logic           err_q, err_d;
   logic           push;
   logic [AW-1:0]  pc_inc;
   logic [AW-1:0]  stack_q [DEPTH];

   assign pc_inc = pc_q + AW'(1);

   // State and status registers
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         state_q <= S_RUN;
         pc_q    <= '0;
         sp_q    <= '0;
         taken_q <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         sp_q    <= sp_d;
         taken_q <= taken_d;
         err_q   <= err_d;
      end
   end

   // Return stack storage; occupancy lives in sp_q so entries need no reset
   always_ff @(posedge CLK) begin
      if (push) begin
         stack_q[IW'(sp_q)] <= pc_inc;
      end
   end

   // Next-state decode; only the RUN state accepts ops
   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      sp_d    = sp_q;
      err_d   = err_q;
      taken_d = 1'b0;
      push    = 1'b0;
      if (bus.EN && (state_q == S_RUN)) begin
         case (op_e'(bus.OP))
            OP_NEXT: pc_d = pc_inc;
            OP_JMP: begin
               pc_d    = bus.TARGET;
               taken_d = 1'b1;
            end
            OP_JC: begin
               pc_d    = bus.C ? bus.TARGET : pc_inc;
               taken_d = bus.C;
            end
            OP_JZ: begin
               pc_d    = bus.Z ? bus.TARGET : pc_inc;
               taken_d = bus.Z;
            end
            OP_JB: begin
               pc_d    = bus.B ? bus.TARGET : pc_inc;
               taken_d = bus.B;
            end
            OP_CALL: begin
               if (sp_q < SPW'(DEPTH)) begin
                  push    = 1'b1;
                  sp_d    = sp_q + SPW'(1);
                  pc_d    = bus.TARGET;
                  taken_d = 1'b1;
               end else begin
                  pc_d  = pc_inc;
                  err_d = 1'b1;
               end
            end
            OP_RET: begin
               if (sp_q != '0) begin
                  sp_d    = sp_q - SPW'(1);
                  pc_d    = stack_q[IW'(sp_q - SPW'(1))];
                  taken_d = 1'b1;
               end else begin
                  pc_d  = pc_inc;
                  err_d = 1'b1;
               end
            end
            OP_HALT: state_d = S_HALT;
            default: pc_d = pc_q;
         endcase
      end
   end

   assign bus.PC      = pc_q;
   assign bus.SP      = sp_q;
   assign bus.TAKEN   = taken_q;
   assign bus.STK_ERR = err_q;
   assign bus.HALTED  = (state_q == S_HALT);
endmodule

// File: tb/tb_cpu_pc_seq.sv
// Directed self-checking bench for cpu_pc_seq (AW=8, DEPTH=4).
module tb_cpu_pc_seq;
   localparam logic [2:0] O_NEXT = 3'b000;
   localparam logic [2:0] O_JMP  = 3'b001;
   localparam logic [2:0] O_JC   = 3'b010;
   localparam logic [2:0] O_JZ   = 3'b011;
   localparam logic [2:0] O_JB   = 3'b100;
   localparam logic [2:0] O_CALL = 3'b101;
   localparam logic [2:0] O_RET  = 3'b110;
   localparam logic [2:0] O_HALT = 3'b111;

   // fl = {C,Z,B,EN}; st = {TAKEN,HALTED,STK_ERR}
   typedef struct packed {
      logic [2:0] op;
      logic [7:0] tgt;
      logic [3:0] fl;
      logic [7:0] pc;
      logic [2:0] st;
      logic [2:0] sp;
   } vec_t;

   logic CLK;
   logic RST;
   int   checks;
   int   failures;
   logic [13:0] obs;
   logic [13:0] exp_v;

   cpu_pc_seq_if #(.AW(8), .DEPTH(4)) bus ();

   cpu_pc_seq #(.AW(8), .DEPTH(4)) dut (
      .CLK (CLK),
      .RST (RST),
      .bus (bus)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   task automatic step(input logic [2:0] op, input logic [7:0] tgt, input logic [3:0] fl);
      bus.OP     = op;
      bus.TARGET = tgt;
      bus.C      = fl[3];
      bus.Z      = fl[2];
      bus.B      = fl[1];
      bus.EN     = fl[0];
      @(posedge CLK);
      #1;
   endtask

   // Asynchronous reset pulse placed between clock edges
   task automatic pulse_reset();
      #2;
      RST = 1'b0;
      #1;
   endtask

   task automatic release_reset();
      #1;
      RST = 1'b1;
   endtask

   task automatic test_reset();
      RST = 1'b0;
      bus.EN = 1'b1; bus.OP = O_JMP; bus.TARGET = 8'h77;
      bus.C = 1'b1; bus.Z = 1'b1; bus.B = 1'b1;
      #1;
      obs = {bus.PC, bus.TAKEN, bus.HALTED, bus.STK_ERR, bus.SP};
      checks++;
      if (obs !== 14'd0) begin
         failures++;
         $display("FAIL reset_async got=%h expected=%h", obs, 14'd0);
      end
      @(posedge CLK); #1;
      obs = {bus.PC, bus.TAKEN, bus.HALTED, bus.STK_ERR, bus.SP};
      checks++;
      if (obs !== 14'd0) begin
         failures++;
         $display("FAIL reset_held got=%h expected=%h", obs, 14'd0);
      end
      release_reset();
   endtask

   task automatic test_next();
      vec_t v [5];
      v = '{'{O_NEXT, 8'h00, 4'b0001, 8'h01, 3'b000, 3'd0},
            '{O_NEXT, 8'h00, 4'b0001, 8'h02, 3'b000, 3'd0},
            '{O_NEXT, 8'h00, 4'b0001, 8'h03, 3'b000, 3'd0},
            '{O_JMP,  8'hFF, 4'b0001, 8'hFF, 3'b100, 3'd0},
            '{O_NEXT, 8'h00, 4'b0001, 8'h00, 3'b000, 3'd0}};
      for (int i = 0; i < 5; i++) begin
         step(v[i].op, v[i].tgt, v[i].fl);
         obs   = {bus.PC, bus.TAKEN, bus.HALTED, bus.STK_ERR, bus.SP};
         exp_v = {v[i].pc, v[i].st, v[i].sp};
         checks++;
         if (obs !== exp_v) begin
            failures++;
            $display("FAIL next[%0d] got=%h expected=%h", i, obs, exp_v);
         end
      end
   endtask

   task automatic test_cond();
      vec_t v [8];
      v = '{'{O_JMP,  8'h10, 4'b0001, 8'h10, 3'b100, 3'd0},
            '{O_JZ,   8'h40, 4'b0001, 8'h11, 3'b000, 3'd0},
            '{O_JC,   8'h40, 4'b1001, 8'h40, 3'b100, 3'd0},
            '{O_NEXT, 8'h00, 4'b0001, 8'h41, 3'b000, 3'd0},
            '{O_JB,   8'h80, 4'b1101, 8'h42, 3'b000, 3'd0},
            '{O_JB,   8'h80, 4'b0011, 8'h80, 3'b100, 3'd0},
            '{O_JZ,   8'h05, 4'b0101, 8'h05, 3'b100, 3'd0},
            '{O_JC,   8'h07, 4'b0111, 8'h06, 3'b000, 3'd0}};
      for (int i = 0; i < 8; i++) begin
         step(v[i].op, v[i].tgt, v[i].fl);
         obs   = {bus.PC, bus.TAKEN, bus.HALTED, bus.STK_ERR, bus.SP};
         exp_v = {v[i].pc, v[i].st, v[i].sp};
         checks++;
         if (obs !== exp_v) begin
            failures++;
            $display("FAIL cond[%0d] got=%h expected=%h", i, obs, exp_v);
         end
      end
   endtask

   task automatic test_call_ret();
      vec_t v [3];
      v = '{'{O_JMP,  8'h05, 4'b0001, 8'h05, 3'b100, 3'd0},
            '{O_CALL, 8'h20, 4'b0001, 8'h20, 3'b100, 3'd1},
            '{O_RET,  8'h00, 4'b0001, 8'h06, 3'b100, 3'd0}};
      for (int i = 0; i < 3; i++) begin
         step(v[i].op, v[i].tgt, v[i].fl);
         obs   = {bus.PC, bus.TAKEN, bus.HALTED, bus.STK_ERR, bus.SP};
         exp_v = {v[i].pc, v[i].st, v[i].sp};
         checks++;
         if (obs !== exp_v) begin
            failures++;
            $display("FAIL call_ret[%0d] got=%h expected=%h", i, obs, exp_v);
         end
      end
   endtask

   task automatic test_stack_limits();
      vec_t v [10];
      v = '{'{O_CALL, 8'h10, 4'b0001, 8'h10, 3'b100, 3'd1},
            '{O_CALL, 8'h20, 4'b0001, 8'h20, 3'b100, 3'd2},
            '{O_CALL, 8'h30, 4'b0001, 8'h30, 3'b100, 3'd3},
            '{O_CALL, 8'h40, 4'b0001, 8'h40, 3'b100, 3'd4},
            '{O_CALL, 8'h50, 4'b0001, 8'h41, 3'b001, 3'd4},
            '{O_RET,  8'h00, 4'b0001, 8'h31, 3'b101, 3'd3},
            '{O_RET,  8'h00, 4'b0001, 8'h21, 3'b101, 3'd2},
            '{O_RET,  8'h00, 4'b0001, 8'h11, 3'b101, 3'd1},
            '{O_RET,  8'h00, 4'b0001, 8'h01, 3'b101, 3'd0},
            '{O_RET,  8'h00, 4'b0001, 8'h02, 3'b001, 3'd0}};
      pulse_reset();
      release_reset();
      for (int i = 0; i < 10; i++) begin
         step(v[i].op, v[i].tgt, v[i].fl);
         obs   = {bus.PC, bus.TAKEN, bus.HALTED, bus.STK_ERR, bus.SP};
         exp_v = {v[i].pc, v[i].st, v[i].sp};
         checks++;
         if (obs !== exp_v) begin
            failures++;
            $display("FAIL stack[%0d] got=%h expected=%h", i, obs, exp_v);
         end
      end
      pulse_reset();
      obs = {bus.PC, bus.TAKEN, bus.HALTED, bus.STK_ERR, bus.SP};
      checks++;
      if (obs !== 14'd0) begin
         failures++;
         $display("FAIL err_cleared got=%h expected=%h", obs, 14'd0);
      end
      release_reset();
      step(O_RET, 8'h00, 4'b0001);
      obs   = {bus.PC, bus.TAKEN, bus.HALTED, bus.STK_ERR, bus.SP};
      exp_v = {8'h01, 3'b001, 3'd0};
      checks++;
      if (obs !== exp_v) begin
         failures++;
         $display("FAIL underflow got=%h expected=%h", obs, exp_v);
      end
   endtask

   task automatic test_halt();
      pulse_reset();
      release_reset();
      step(O_JMP, 8'h33, 4'b0001);
      step(O_HALT, 8'h00, 4'b0001);
      obs   = {bus.PC, bus.TAKEN, bus.HALTED, bus.STK_ERR, bus.SP};
      exp_v = {8'h33, 3'b010, 3'd0};
      checks++;
      if (obs !== exp_v) begin
         failures++;
         $display("FAIL halt_enter got=%h expected=%h", obs, exp_v);
      end
      for (int i = 0; i < 10; i++) begin
         step(O_JMP, 8'h99, 4'b1111);
         obs = {bus.PC, bus.TAKEN, bus.HALTED, bus.STK_ERR, bus.SP};
         checks++;
         if (obs !== exp_v) begin
            failures++;
            $display("FAIL halt_hold[%0d] got=%h expected=%h", i, obs, exp_v);
         end
      end
      pulse_reset();
      obs = {bus.PC, bus.TAKEN, bus.HALTED, bus.STK_ERR, bus.SP};
      checks++;
      if (obs !== 14'd0) begin
         failures++;
         $display("FAIL halt_reset got=%h expected=%h", obs, 14'd0);
      end
      release_reset();
      step(O_NEXT, 8'h00, 4'b0001);
      obs   = {bus.PC, bus.TAKEN, bus.HALTED, bus.STK_ERR, bus.SP};
      exp_v = {8'h01, 3'b000, 3'd0};
      checks++;
      if (obs !== exp_v) begin
         failures++;
         $display("FAIL halt_resume got=%h expected=%h", obs, exp_v);
      end
   endtask

   task automatic test_stall();
      vec_t v [5];
      v = '{'{O_CALL, 8'h22, 4'b0001, 8'h22, 3'b100, 3'd1},
            '{O_JMP,  8'h80, 4'b1110, 8'h22, 3'b000, 3'd1},
            '{O_JMP,  8'h80, 4'b1110, 8'h22, 3'b000, 3'd1},
            '{O_JMP,  8'h80, 4'b1110, 8'h22, 3'b000, 3'd1},
            '{O_NEXT, 8'h00, 4'b0001, 8'h23, 3'b000, 3'd1}};
      pulse_reset();
      release_reset();
      for (int i = 0; i < 5; i++) begin
         step(v[i].op, v[i].tgt, v[i].fl);
         obs   = {bus.PC, bus.TAKEN, bus.HALTED, bus.STK_ERR, bus.SP};
         exp_v = {v[i].pc, v[i].st, v[i].sp};
         checks++;
         if (obs !== exp_v) begin
            failures++;
            $display("FAIL stall[%0d] got=%h expected=%h", i, obs, exp_v);
         end
      end
   endtask

   // Continues from test_stall: PC=0x23, stack holds 0x01
   task automatic test_back_to_back();
      vec_t v [6];
      v = '{'{O_JMP,  8'h10, 4'b0001, 8'h10, 3'b100, 3'd1},
            '{O_JMP,  8'h20, 4'b0001, 8'h20, 3'b100, 3'd1},
            '{O_CALL, 8'h30, 4'b0001, 8'h30, 3'b100, 3'd2},
            '{O_RET,  8'h00, 4'b0001, 8'h21, 3'b100, 3'd1},
            '{O_RET,  8'h00, 4'b0001, 8'h01, 3'b100, 3'd0},
            '{O_NEXT, 8'h00, 4'b0001, 8'h02, 3'b000, 3'd0}};
      for (int i = 0; i < 6; i++) begin
         step(v[i].op, v[i].tgt, v[i].fl);
         obs   = {bus.PC, bus.TAKEN, bus.HALTED, bus.STK_ERR, bus.SP};
         exp_v = {v[i].pc, v[i].st, v[i].sp};
         checks++;
         if (obs !== exp_v) begin
            failures++;
            $display("FAIL b2b[%0d] got=%h expected=%h", i, obs, exp_v);
         end
      end
   endtask

   task automatic test_reset_midstack();
      step(O_CALL, 8'h60, 4'b0001);
      step(O_CALL, 8'h70, 4'b0001);
      bus.OP = O_CALL; bus.TARGET = 8'h90;
      pulse_reset();
      obs = {bus.PC, bus.TAKEN, bus.HALTED, bus.STK_ERR, bus.SP};
      checks++;
      if (obs !== 14'd0) begin
         failures++;
         $display("FAIL midstack_reset got=%h expected=%h", obs, 14'd0);
      end
      release_reset();
      step(O_RET, 8'h00, 4'b0001);
      obs   = {bus.PC, bus.TAKEN, bus.HALTED, bus.STK_ERR, bus.SP};
      exp_v = {8'h01, 3'b001, 3'd0};
      checks++;
      if (obs !== exp_v) begin
         failures++;
         $display("FAIL midstack_ret got=%h expected=%h", obs, exp_v);
      end
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      test_reset();
      test_next();
      test_cond();
      test_call_ret();
      test_stack_limits();
      test_halt();
      test_stall();
      test_back_to_back();
      test_reset_midstack();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
